fifo2: RTL and testbench
========================

Name: fifo2

Overview:
- Single-clock synchronous FIFO; next generation of the team's FIFO family for same-domain buffering.
- Adds, compared with the dual-clock FIFO:
  - occupancy count
  - programmable almost-full and almost-empty flags
  - sticky overflow and underflow flags
  - synchronous flush
  - selectable first-word-fall-through (FWFT) or standard read mode
- Placed between same-clock producer/consumer stages (e.g. datapath decoupling, burst absorption).

Parameters:
- DSIZE, 8, data width in bits
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries
- AFULL_TH, 12, afull asserts when count >= AFULL_TH (legal range 1..DEPTH)
- AEMPTY_TH, 4, aempty asserts when count <= AEMPTY_TH (legal range 0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
- clk  input  1  sole clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous clear of contents
- wdata  input  DSIZE  write data
- winc  input  1  write request
- rinc  input  1  read request (pop)
- rdata  output  DSIZE  read data
- wfull  output  1  count == DEPTH
- rempty  output  1  count == 0
- afull  output  1  almost full
- aempty  output  1  almost empty
- count  output  ASIZE+1  occupancy, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. Priority order: rst > flush > winc/rinc.
- Reset values: wptr = 0, rptr = 0, count = 0, rempty = 1, wfull = 0, aempty = 1, afull = 0, overflow = 0, underflow = 0, rdata = 0. Memory contents are not reset.
- Pointers: wptr and rptr are (ASIZE+1)-bit binary. Address = low ASIZE bits; the MSB is the wrap bit.
  - count = wptr - rptr, modulo 2**(ASIZE+1).
  - wfull when the addresses are equal and the wrap bits differ.
  - rempty when wptr == rptr.
- Write accept: `wen = winc & ~wfull & ~flush`. On wen, mem[waddr] <= wdata and wptr increments.
- Read accept: `ren = rinc & ~rempty & ~flush`. On ren, rptr increments.
- Flags use registered state only: wfull blocks a write even if a read is accepted in the same cycle. rempty blocks a read even if a write is accepted in the same cycle.
- Simultaneous wen and ren: both occur and count is unchanged. Legal at any count in 1..DEPTH-1.
- Flag timing: wfull, rempty, afull, aempty and count are combinational from registered pointers. They update in the same edge as the causing operation, so they reflect state after the edge.
- Overflow/underflow:
  - overflow sets on winc & wfull & ~flush; underflow sets on rinc & rempty & ~flush.
  - Both cleared only by rst; flush does not clear them.
- Flush: wptr <= 0 and rptr <= 0. Any winc/rinc in the same cycle is dropped. rdata holds its value in standard mode.
- Standard mode (FWFT = 0):
  - rdata is a register loaded with mem[raddr] on ren.
  - Valid the cycle after the accepting edge; holds otherwise.
- FWFT mode (FWFT = 1):
  - rdata = mem[raddr], an asynchronous read that always shows the head word.
  - Valid whenever rempty = 0. A word written at edge N is visible after edge N.
  - rinc acknowledges (pops) the current word.
  - rdata is don't-care while rempty = 1.
- Wrap-around: pointers roll over naturally at 2**(ASIZE+1). No special case is needed.

Decomposition:
- Shared package fifo_pkg:
  - localparams FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1
  - function clog2
  - helper depth(ASIZE)
- One sub-module, fifo2_mem: DEPTH × DSIZE array, synchronous write with enable, asynchronous read. The top selects the registered or direct read path via a FWFT generate.
- Pointer, count and flag logic stays in fifo2.

Test Plan:
- Reset, then write 16 words 0x00..0x0F with no reads:
  - count steps 1..16
  - afull rises at count = 12; aempty falls at count = 5; wfull = 1 at count = 16
  - a 17th winc leaves count = 16 and sets overflow = 1
- Full FIFO, then rinc × 16 in FWFT = 0:
  - rdata = 0x00..0x0F, each one cycle after its pop
  - rempty = 1 after the last pop
  - an extra rinc sets underflow = 1 and leaves rdata at 0x0F
- FWFT = 1, single write of 0xA5 to an empty FIFO:
  - after that edge rempty = 0 and rdata = 0xA5 with no rinc
  - rinc → rempty = 1
- Count = 8, then 40 cycles of winc = rinc = 1 with an incrementing pattern:
  - count stays 8
  - data order preserved across pointer wrap; no flag toggles
- Count = 16 (full), winc = rinc = 1 for one cycle:
  - read accepted, write rejected, overflow = 1, count = 15
- Count = 10, flush = 1 with winc = 1:
  - count = 0, rempty = 1, aempty = 1, overflow unchanged
  - the next write/read round-trips correctly
  - rst mid-burst returns all outputs to their reset values on the next edge

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family.
// Read-mode selectors and sizing helpers.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int depth(input int asize);
    return 1 << asize;
  endfunction

endpackage

// File: rtl/fifo2_mem.sv
// FIFO storage: DEPTH x DSIZE array.
// Synchronous write with enable, asynchronous read.
module fifo2_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  localparam int DEPTH = depth(ASIZE);

  logic [DSIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo2.sv
// Single-clock FIFO with count, almost flags, sticky errors,
// synchronous flush and selectable standard / FWFT read.
module fifo2
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             afull,
  output logic             aempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ASIZE:0] LP_AF = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] LP_AE = (ASIZE+1)'(AEMPTY_TH);

  logic [ASIZE:0]   r_wptr;
  logic [ASIZE:0]   r_rptr;
  logic             r_ovf;
  logic             r_unf;
  logic             w_wen;
  logic             w_ren;
  logic [DSIZE-1:0] w_mem_rdata;

  assign count  = r_wptr - r_rptr;
  assign rempty = (r_wptr == r_rptr);
  assign wfull  = (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]) &&
                  (r_wptr[ASIZE] != r_rptr[ASIZE]);
  assign afull  = (count >= LP_AF);
  assign aempty = (count <= LP_AE);

  // Accepts use registered flags only: a same-cycle pop never frees a full slot.
  assign w_wen = winc & ~wfull & ~flush & ~rst;
  assign w_ren = rinc & ~rempty & ~flush & ~rst;

  assign overflow  = r_ovf;
  assign underflow = r_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wen) r_wptr <= r_wptr + 1'b1;
      if (w_ren) r_rptr <= r_rptr + 1'b1;
      if (winc & wfull) r_ovf <= 1'b1;
      if (rinc & rempty) r_unf <= 1'b1;
    end
  end

  fifo2_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wen),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rdata = w_mem_rdata;
    end else begin : g_std
      logic [DSIZE-1:0] r_rdata;
      always_ff @(posedge clk) begin
        if (rst) r_rdata <= '0;
        else if (w_ren) r_rdata <= w_mem_rdata;
      end
      assign rdata = r_rdata;
    end
  endgenerate

endmodule

// File: tb/tb_fifo2.sv
// Self-checking bench: standard and FWFT instances share stimulus
// and are compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_fifo2;

  logic       clk = 1'b0;
  logic       rst, flush, winc, rinc;
  logic [7:0] wdata;

  logic [7:0] s_rdata, f_rdata;
  logic       s_wfull, s_rempty, s_afull, s_aempty, s_ovf, s_unf;
  logic       f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_unf;
  logic [4:0] s_count, f_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic       m_ovf, m_unf;
  logic [7:0] m_rd;

  always #5 clk = ~clk;

  fifo2 #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata),
    .winc(winc), .rinc(rinc), .rdata(s_rdata),
    .wfull(s_wfull), .rempty(s_rempty), .afull(s_afull),
    .aempty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  fifo2 #(.FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata),
    .winc(winc), .rinc(rinc), .rdata(f_rdata),
    .wfull(f_wfull), .rempty(f_rempty), .afull(f_afull),
    .aempty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("s_count",  32'(s_count),  32'(n));
    chk("f_count",  32'(f_count),  32'(n));
    chk("s_rempty", 32'(s_rempty), 32'(n == 0));
    chk("f_rempty", 32'(f_rempty), 32'(n == 0));
    chk("s_wfull",  32'(s_wfull),  32'(n == 16));
    chk("f_wfull",  32'(f_wfull),  32'(n == 16));
    chk("s_afull",  32'(s_afull),  32'(n >= 12));
    chk("f_afull",  32'(f_afull),  32'(n >= 12));
    chk("s_aempty", 32'(s_aempty), 32'(n <= 4));
    chk("f_aempty", 32'(f_aempty), 32'(n <= 4));
    chk("s_ovf",    32'(s_ovf),    32'(m_ovf));
    chk("f_ovf",    32'(f_ovf),    32'(m_ovf));
    chk("s_unf",    32'(s_unf),    32'(m_unf));
    chk("f_unf",    32'(f_unf),    32'(m_unf));
    chk("s_rdata",  32'(s_rdata),  32'(m_rd));
    if (n != 0) chk("f_rdata", 32'(f_rdata), 32'(q[0]));
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic f = 1'b0, input logic rs = 1'b0);
    bit full, empty;
    winc = w; rinc = r; wdata = d; flush = f; rst = rs;
    @(posedge clk);
    #1;
    full  = (q.size() == 16);
    empty = (q.size() == 0);
    if (rs) begin
      q.delete(); m_ovf = 0; m_unf = 0; m_rd = 8'h00;
    end else if (f) begin
      q.delete();
    end else begin
      if (w && full) m_ovf = 1;
      if (r && empty) m_unf = 1;
      if (r && !empty) m_rd = q.pop_front();
      if (w && !full) q.push_back(d);
    end
    winc = 0; rinc = 0; flush = 0; rst = 0;
    check_all();
  endtask

  initial begin
    rst = 1; flush = 0; winc = 0; rinc = 0; wdata = 0;
    m_ovf = 0; m_unf = 0; m_rd = 0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0);

    for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
    step(1, 0, 8'hEE);
    chk("ovf_after_17th", 32'(s_ovf), 32'd1);
    chk("count_after_17th", 32'(s_count), 32'd16);

    for (int i = 0; i < 16; i++) step(0, 1, 0);
    step(0, 1, 0);
    chk("unf_after_extra", 32'(s_unf), 32'd1);
    chk("rdata_hold_0f", 32'(s_rdata), 32'h0F);

    step(1, 0, 8'hA5);
    chk("fwft_a5", 32'(f_rdata), 32'hA5);
    step(0, 1, 0);

    for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h40 + i));

    for (int i = 0; i < 8; i++) step(1, 0, 8'($urandom));
    step(1, 1, 8'h99);
    chk("full_rw_count", 32'(s_count), 32'd15);

    for (int i = 0; i < 5; i++) step(0, 1, 0);
    step(1, 0, 8'h11, 1);
    chk("flush_count", 32'(f_count), 32'd0);
    step(1, 0, 8'h3C);
    step(0, 1, 0);
    chk("roundtrip", 32'(s_rdata), 32'h3C);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           8'($urandom), $urandom_range(0, 99) < 3,
           $urandom_range(0, 199) < 2);
    end

    for (int i = 0; i < 6; i++) step(1, 1, 8'($urandom));
    step(1, 1, 8'h77, 0, 1);
    chk("rst_rdata", 32'(s_rdata), 32'd0);
    chk("rst_count", 32'(f_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
